// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser and per-bit debouncer for slide switches
// Each bit accepts a new level only after it persists STABLE_CYCLES cycles; emits rise/fall strobes.
module switch_debouncer #(
   parameter int WIDTH         = 3,
   parameter int STABLE_CYCLES = 500000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
);

   localparam logic STABLE  = 1'b0;
   localparam logic PENDING = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] state;
   logic [CNT_W-1:0] cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // State is implied by whether the synchronised input disagrees with the accepted level.
   always_comb begin
      state = '0;
      for (int i = 0; i < WIDTH; i++) begin
         state[i] = (sync2[i] != sw_db[i]) ? PENDING : STABLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_db   <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sw_rise <= '0;
         sw_fall <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            case (state[i])
               PENDING: begin
                  if (cnt[i] == CNT_LAST) begin
                     sw_db[i]   <= sync2[i];
                     sw_rise[i] <= sync2[i];
                     sw_fall[i] <= ~sync2[i];
                     cnt[i]     <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_ONE;
                  end
               end
               default: cnt[i] <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer
module tb_switch_debouncer;

   typedef struct packed {
      logic [2:0] db;
      logic [2:0] rise;
      logic [2:0] fall;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [2:0] sw_raw;
   logic [2:0] sw_db;
   logic [2:0] sw_rise;
   logic [2:0] sw_fall;
   logic [2:0] sw_raw1;
   logic [2:0] sw_db1;
   logic [2:0] sw_rise1;
   logic [2:0] sw_fall1;
   logic       mux_f;

   exp_t sbq[$];
   exp_t ex;
   int   checks;
   int   errors;

   switch_debouncer #(.WIDTH(3), .STABLE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .sw_raw(sw_raw),
      .sw_db(sw_db), .sw_rise(sw_rise), .sw_fall(sw_fall)
   );

   switch_debouncer #(.WIDTH(3), .STABLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .sw_raw(sw_raw1),
      .sw_db(sw_db1), .sw_rise(sw_rise1), .sw_fall(sw_fall1)
   );

   // Downstream mux: sw_db[0] -> in0, sw_db[1] -> in1, sw_db[2] -> sel
   assign mux_f = sw_db[2] ? sw_db[1] : sw_db[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      sw_raw  = 3'b111;
      sw_raw1 = 3'b000;
      for (int e = 0; e < 3; e++) begin
         sbq.push_back('{db: 3'b000, rise: 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL reset_db cyc %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL reset_rise cyc %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL reset_fall cyc %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
   endtask

   task automatic test_clean_step();
      reset  = 1'b0;
      sw_raw = 3'b001;
      for (int e = 0; e < 8; e++) begin
         sbq.push_back('{db: (e >= 5) ? 3'b001 : 3'b000, rise: (e == 5) ? 3'b001 : 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL step_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL step_rise edge %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL step_fall edge %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
   endtask

   task automatic test_bounce();
      for (int e = 0; e < 16; e++) begin
         sw_raw[1] = (e < 12) ? (((e / 2) % 2) == 0) : 1'b0;
         sbq.push_back('{db: 3'b001, rise: 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL bounce_db cyc %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL bounce_rise cyc %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL bounce_fall cyc %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
      sw_raw[1] = 1'b1;
      for (int e = 0; e < 8; e++) begin
         sbq.push_back('{db: (e >= 5) ? 3'b011 : 3'b001, rise: (e == 5) ? 3'b010 : 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL settle_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL settle_rise edge %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL settle_fall edge %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
   endtask

   task automatic test_simultaneous();
      sw_raw = 3'b100;
      for (int e = 0; e < 8; e++) begin
         sbq.push_back('{db: (e >= 5) ? 3'b100 : 3'b011, rise: (e == 5) ? 3'b100 : 3'b000,
                         fall: (e == 5) ? 3'b011 : 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL simul_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL simul_rise edge %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL simul_fall edge %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
   endtask

   task automatic test_reset_midcount();
      sw_raw = 3'b010;
      // Edges 0..3 leave cnt[1] at 2 for the pending rise.
      for (int e = 0; e < 4; e++) begin
         sbq.push_back('{db: 3'b100, rise: 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL midpre_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL midpre_rise edge %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL midpre_fall edge %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
      reset = 1'b1;
      sbq.push_back('{db: 3'b000, rise: 3'b000, fall: 3'b000});
      step();
      reset = 1'b0;
      ex = sbq.pop_front();
      checks += 3;
      if (sw_db !== ex.db) begin errors++; $display("FAIL midrst_db got %b exp %b", sw_db, ex.db); end
      if (sw_rise !== ex.rise) begin errors++; $display("FAIL midrst_rise got %b exp %b", sw_rise, ex.rise); end
      if (sw_fall !== ex.fall) begin errors++; $display("FAIL midrst_fall got %b exp %b", sw_fall, ex.fall); end
      for (int e = 1; e <= 8; e++) begin
         sbq.push_back('{db: (e >= 6) ? 3'b010 : 3'b000, rise: (e == 6) ? 3'b010 : 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL midpost_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL midpost_rise edge %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL midpost_fall edge %0d got %b exp %b", e, sw_fall, ex.fall); end
      end
   endtask

   task automatic test_mux();
      logic exp_f;
      sw_raw = 3'b110;
      for (int e = 0; e < 8; e++) begin
         sbq.push_back('{db: (e >= 5) ? 3'b110 : 3'b010, rise: (e == 5) ? 3'b100 : 3'b000, fall: 3'b000});
         exp_f = (e >= 5);
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL mux1_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_rise !== ex.rise) begin errors++; $display("FAIL mux1_rise edge %0d got %b exp %b", e, sw_rise, ex.rise); end
         if (mux_f !== exp_f) begin errors++; $display("FAIL mux1_f edge %0d got %b exp %b", e, mux_f, exp_f); end
      end
      sw_raw = 3'b010;
      for (int e = 0; e < 8; e++) begin
         sbq.push_back('{db: (e >= 5) ? 3'b010 : 3'b110, rise: 3'b000, fall: (e == 5) ? 3'b100 : 3'b000});
         exp_f = (e < 5);
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db !== ex.db) begin errors++; $display("FAIL mux2_db edge %0d got %b exp %b", e, sw_db, ex.db); end
         if (sw_fall !== ex.fall) begin errors++; $display("FAIL mux2_fall edge %0d got %b exp %b", e, sw_fall, ex.fall); end
         if (mux_f !== exp_f) begin errors++; $display("FAIL mux2_f edge %0d got %b exp %b", e, mux_f, exp_f); end
      end
   endtask

   task automatic test_min_stable();
      sw_raw1 = 3'b101;
      for (int e = 0; e < 4; e++) begin
         sbq.push_back('{db: (e >= 2) ? 3'b101 : 3'b000, rise: (e == 2) ? 3'b101 : 3'b000, fall: 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db1 !== ex.db) begin errors++; $display("FAIL min_rise_db edge %0d got %b exp %b", e, sw_db1, ex.db); end
         if (sw_rise1 !== ex.rise) begin errors++; $display("FAIL min_rise_rise edge %0d got %b exp %b", e, sw_rise1, ex.rise); end
         if (sw_fall1 !== ex.fall) begin errors++; $display("FAIL min_rise_fall edge %0d got %b exp %b", e, sw_fall1, ex.fall); end
      end
      sw_raw1 = 3'b000;
      for (int e = 0; e < 4; e++) begin
         sbq.push_back('{db: (e >= 2) ? 3'b000 : 3'b101, rise: 3'b000, fall: (e == 2) ? 3'b101 : 3'b000});
         step();
         ex = sbq.pop_front();
         checks += 3;
         if (sw_db1 !== ex.db) begin errors++; $display("FAIL min_fall_db edge %0d got %b exp %b", e, sw_db1, ex.db); end
         if (sw_rise1 !== ex.rise) begin errors++; $display("FAIL min_fall_rise edge %0d got %b exp %b", e, sw_rise1, ex.rise); end
         if (sw_fall1 !== ex.fall) begin errors++; $display("FAIL min_fall_fall edge %0d got %b exp %b", e, sw_fall1, ex.fall); end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      sw_raw  = 3'b000;
      sw_raw1 = 3'b000;
      test_reset();
      test_clean_step();
      test_bounce();
      test_simultaneous();
      test_reset_midcount();
      test_mux();
      test_min_stable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Upstream conditioning stage for the board slide switches: synchronises the raw SW[2:0] inputs to the system clock and debounces each bit independently. The debounced bus drives the mux stage: sw_db[0] feeds in0, sw_db[1] feeds in1, and sw_db[2] feeds sel. The block also emits single-cycle rise and fall strobes per bit for downstream sequential logic.

Parameters:
WIDTH, 3, number of independent switch bits.
STABLE_CYCLES, 500000, consecutive cycles a new level must persist before it is accepted. At 50 MHz this is 10 ms. Legal range is 1 or more.
CNT_W, $clog2(STABLE_CYCLES+1), width of each per-bit counter. Derived; do not override.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
sw_raw  input  WIDTH  raw asynchronous switch levels (SW).
sw_db  output  WIDTH  debounced, registered switch levels.
sw_rise  output  WIDTH  one-cycle pulse when sw_db[i] goes 0->1.
sw_fall  output  WIDTH  one-cycle pulse when sw_db[i] goes 1->0.

Behaviour:
- One clock domain. Reset is synchronous, active-high and dominant over all other activity.
- Reset clears all of the following to 0 on the next rising edge:
  - both synchroniser stages (sync1, sync2);
  - all counters;
  - sw_db, sw_rise and sw_fall.
- Synchroniser: sync1[i] <= sw_raw[i], then sync2[i] <= sync1[i]. No logic is placed between the two flops.
- Each bit i has an independent two-state machine.
  - STABLE: entered when sync2[i] == sw_db[i]. In this state cnt[i] <= 0.
  - PENDING: entered when sync2[i] != sw_db[i].
    - If cnt[i] == STABLE_CYCLES-1: sw_db[i] <= sync2[i] and cnt[i] <= 0. Pulse sw_rise[i] or sw_fall[i] for exactly one cycle, matching the new level. Return to STABLE.
    - Otherwise: cnt[i] <= cnt[i]+1.
- Glitch rejection: any cycle with sync2 == sw_db restarts the count at 0. A bounce shorter than STABLE_CYCLES never reaches sw_db.
- Latency: suppose sw_raw[i] changes and is first sampled at edge k, then stays constant. sw_db[i] updates at edge k+1+STABLE_CYCLES. The rise or fall strobe is high during the cycle after that edge.
- Strobes:
  - Registered.
  - Low in every cycle except the single update cycle.
  - sw_rise[i] and sw_fall[i] are never high together.
- Bits are fully independent. Simultaneous changes on several bits update on the same edge and pulse their strobes together.
- The counter never exceeds STABLE_CYCLES-1. No wrap-around is possible.
- Reset mid-count: the pending change is discarded. After reset deasserts, an input held high needs the full 2+STABLE_CYCLES-edge sequence again before sw_db rises.
- STABLE_CYCLES=1: a change is accepted after one mismatch cycle, so latency is 2 edges.
- All outputs come straight from flops; there are no combinational paths from sw_raw to any output.

Test Plan:
1. Reset behaviour (WIDTH=3, STABLE_CYCLES=4): hold reset 3 cycles with sw_raw=3'b111 -> sw_db, sw_rise and sw_fall are all 3'b000 throughout.
2. Clean step: after reset, sw_raw=3'b001, first sampled at edge 0 -> sw_db=3'b001 after edge 5, sw_rise=3'b001 for exactly one cycle, sw_fall stays 0.
3. Bounce rejection: sw_raw[1] toggles 1,0,1,0 every 2 cycles for 12 cycles and then returns to 0 -> sw_db[1] stays 0 and no strobes fire. Then sw_raw[1]=1 held for 6 cycles -> sw_db[1]=1 after edge 5 counted from its first sample.
4. Simultaneous change: sw_db=3'b011 when sw_raw goes to 3'b100 -> on the same edge sw_db=3'b100, sw_rise=3'b100 and sw_fall=3'b011, each for one cycle.
5. Reset mid-count: sw_raw=3'b010 held; assert reset for 1 cycle when cnt[1]=2 -> sw_db[1] stays 0 and then rises at the 6th edge after reset deasserts.
6. Mux integration: feed sw_db into the mux with sw_raw=3'b110 -> f=1 after settling. Change to 3'b010 -> f=0 exactly 5 edges after the first sample.
